dmem_responder: RTL

- Memory-side responder for the core's load-store port, at the opposite end from the core's LoadStore stage.
- Accepts one request per cycle: read or write, byte/half/word, with a word-addressed backing array.
- Returns read data right-aligned after a fixed pipelined latency, and flags misaligned or out-of-range accesses.
- Used as the data memory in core-level simulation and as the FPGA data memory.

---
 rtl/memory_pkg.sv | 34 +++
 rtl/dmem_lane_extract.sv | 23 ++
 rtl/dmem_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared types for the data/instruction memory responders: access sizes,
// the response pipeline entry and the byte-lane enable helper.
package memory_pkg;

   localparam int unsigned MEM_WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } e_mem_size;

   typedef struct packed {
      logic                      valid;
      logic                      err;
      logic                      is_load;
      logic [1:0]                lane_off;
      logic [1:0]                size;
      logic [MEM_WORD_WIDTH-1:0] word;
   } mem_pipe_t;

   // Reserved size yields no enabled lanes.
   function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] mask;
      case (size)
         MEM_BYTE: mask = 4'b0001;
         MEM_HALF: mask = 4'b0011;
         MEM_WORD: mask = 4'b1111;
         default:  mask = 4'b0000;
      endcase
      return mask << off;
   endfunction

endpackage

// File: rtl/dmem_lane_extract.sv
// Shifts the addressed lane of a memory word down to bit 0 and zero-extends
// it to the access size. Purely combinational.
module dmem_lane_extract
   import memory_pkg::*;
(
   input  logic [MEM_WORD_WIDTH-1:0] i_word,
   input  logic [1:0]                i_off,
   input  logic [1:0]                i_size,
   output logic [MEM_WORD_WIDTH-1:0] o_data
);

   logic [MEM_WORD_WIDTH-1:0] w_shifted;

   always_comb begin
      w_shifted = i_word >> {i_off, 3'b000};
      case (i_size)
         MEM_BYTE: o_data = {24'h0, w_shifted[7:0]};
         MEM_HALF: o_data = {16'h0, w_shifted[15:0]};
         default:  o_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-port word array with a fixed-latency load pipeline.
// Optional saturating access counters are built when DMEM_RESPONDER_STATS_EN is defined.
module dmem_responder
   import memory_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DEPTH_WORDS = 1024,
   parameter int unsigned       LATENCY     = 2,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              write,
   input  logic [1:0]        n_bytes,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic              addr_err
`ifdef DMEM_RESPONDER_STATS_EN
   ,
   output logic [31:0]       stat_loads,
   output logic [31:0]       stat_stores,
   output logic [31:0]       stat_errors
`endif
);

   localparam int unsigned     IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_W:0] BYTE_RANGE = (ADDR_W+1)'(4 * DEPTH_WORDS);

   logic [31:0]      r_mem [DEPTH_WORDS];
   mem_pipe_t        r_pipe [LATENCY];
   mem_pipe_t        w_stage_in [LATENCY];
   mem_pipe_t        w_entry;
   mem_pipe_t        w_last_next;
   logic [ADDR_W:0]  w_off;
   logic [IDX_W-1:0] w_idx;
   logic             w_misalign;
   logic             w_err;
   logic             w_we;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [31:0]      w_extract;

   // One extra bit so addresses below BASE_ADDR land far out of range instead of wrapping.
   assign w_off = {1'b0, addr} - {1'b0, BASE_ADDR};
   assign w_idx = w_off[IDX_W+1:2];

   always_comb begin
      w_misalign = ((n_bytes == MEM_HALF) && addr[0]) ||
                   ((n_bytes == MEM_WORD) && (addr[1:0] != 2'b00));
      w_err      = req & (w_misalign | (n_bytes == 2'd3) | (w_off >= BYTE_RANGE));
      w_we       = req & write & ~w_err;
      w_be       = byte_enable(n_bytes, addr[1:0]);
      case (n_bytes)
         MEM_BYTE: w_wdata = {4{wdata[7:0]}};
         MEM_HALF: w_wdata = {2{wdata[15:0]}};
         default:  w_wdata = wdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      w_entry          = '0;
      w_entry.valid    = req;
      w_entry.err      = w_err;
      w_entry.is_load  = ~write;
      w_entry.lane_off = addr[1:0];
      w_entry.size     = n_bytes;
      w_entry.word     = r_mem[w_idx];
   end

   always_comb begin
      w_stage_in[0] = w_entry;
      for (int i = 1; i < LATENCY; i++) w_stage_in[i] = r_pipe[i-1];
   end

   dmem_lane_extract u_lane_extract (
      .i_word (w_stage_in[LATENCY-1].word),
      .i_off  (w_stage_in[LATENCY-1].lane_off),
      .i_size (w_stage_in[LATENCY-1].size),
      .o_data (w_extract)
   );

   // Final stage word is the rdata register: it holds unless a load or an error arrives.
   always_comb begin
      w_last_next      = w_stage_in[LATENCY-1];
      w_last_next.word = r_pipe[LATENCY-1].word;
      if (w_stage_in[LATENCY-1].valid) begin
         if (w_stage_in[LATENCY-1].err) w_last_next.word = '0;
         else if (w_stage_in[LATENCY-1].is_load) w_last_next.word = w_extract;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
      end else begin
         for (int i = 0; i < LATENCY - 1; i++) r_pipe[i] <= w_stage_in[i];
         r_pipe[LATENCY-1] <= w_last_next;
      end
   end

   assign rdata    = r_pipe[LATENCY-1].word;
   assign rvalid   = r_pipe[LATENCY-1].valid & r_pipe[LATENCY-1].is_load & ~r_pipe[LATENCY-1].err;
   assign addr_err = r_pipe[LATENCY-1].valid & r_pipe[LATENCY-1].err;

`ifdef DMEM_RESPONDER_STATS_EN
   logic [31:0] r_stat_loads;
   logic [31:0] r_stat_stores;
   logic [31:0] r_stat_errors;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_loads  <= '0;
         r_stat_stores <= '0;
         r_stat_errors <= '0;
      end else begin
         if (req && !write && !w_err && !(&r_stat_loads)) r_stat_loads <= r_stat_loads + 32'd1;
         if (w_we && !(&r_stat_stores)) r_stat_stores <= r_stat_stores + 32'd1;
         if (w_err && !(&r_stat_errors)) r_stat_errors <= r_stat_errors + 32'd1;
      end
   end

   assign stat_loads  = r_stat_loads;
   assign stat_stores = r_stat_stores;
   assign stat_errors = r_stat_errors;
`endif

endmodule
